// File: rtl/if_pkg.sv
// if_pkg: shared fetch-stage types and constants
package if_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  localparam logic [31:0] NOP_DEFAULT = 32'hE1A0_0000;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/if_fetch_unit_stage_reg.sv
// if_stage_reg: IF/ID pipeline register where flush dominates hold
module if_stage_reg #(
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic        d_valid,
  output logic [31:0] q_pc,
  output logic [31:0] q_instr,
  output logic        q_valid
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_pc <= 32'd0;
      q_instr <= NOP_INSTR;
      q_valid <= 1'b0;
    end else if (!hold) begin
      q_pc <= d_pc;
      q_instr <= d_instr;
      q_valid <= d_valid;
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC, the imem request/ready port and the IF/ID register
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_Address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        IF_valid
);
  state_t state;
  logic [31:0] pc_reg, pc_inc, br_addr, hold_pc, hold_instr, redirect_reg, d_pc, d_instr;
  logic hold_valid, rdy, fetched, d_valid;
  assign imem_req = state != HOLD;
  assign imem_addr = pc_reg;
  assign rdy = imem_ready & imem_req;
  assign fetched = state == FETCH && rdy;
  assign pc_inc = pc_reg + PC_STEP;
  assign br_addr = {Branch_Address[31:2], 2'b00};
  always_comb begin
    d_pc = state == HOLD ? hold_pc : fetched ? pc_inc : PC;
    d_instr = state == HOLD ? hold_instr : fetched ? imem_rdata : NOP_INSTR;
    d_valid = state == HOLD ? hold_valid : fetched;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
      state <= FETCH;
      hold_valid <= 1'b0;
      hold_pc <= 32'd0;
      hold_instr <= NOP_INSTR;
      redirect_reg <= 32'd0;
    end else if (Branch_taken) begin
      hold_valid <= 1'b0;
      if (state == HOLD || rdy) begin
        pc_reg <= br_addr;
        state <= FETCH;
      end else begin
        redirect_reg <= br_addr;
        state <= DRAIN;
      end
    end else begin
      case (state)
        FETCH: if (rdy) begin
          pc_reg <= pc_inc;
          if (freeze) begin
            hold_pc <= pc_inc;
            hold_instr <= imem_rdata;
            hold_valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: if (!freeze) begin
          hold_valid <= 1'b0;
          state <= FETCH;
        end
        DRAIN: if (rdy) begin
          pc_reg <= redirect_reg;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
  if_stage_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk(clk),
    .rst(rst),
    .flush(Branch_taken),
    .hold(freeze),
    .d_pc(d_pc),
    .d_instr(d_instr),
    .d_valid(d_valid),
    .q_pc(PC),
    .q_instr(Instruction),
    .q_valid(IF_valid)
  );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized fetch-stage bench against a transaction-level reference model
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'hE1A0_0000;
  logic clk = 1'b0, rst = 1'b1, freeze = 1'b0, Branch_taken = 1'b0, imem_ready = 1'b0;
  logic [31:0] Branch_Address = 32'd0, imem_rdata = 32'd0;
  logic imem_req, IF_valid;
  logic [31:0] imem_addr, PC, Instruction;
  int compared = 0, mismatched = 0;
  logic [31:0] m_pc, mo_pc, mo_ins, tgt;
  logic mo_v, drop;
  logic [63:0] hbuf[$];
  int wait_cnt = 0, cur_lat = 0, lat_lo = 0, lat_hi = 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(Branch_taken),
    .Branch_Address(Branch_Address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC(PC),
    .Instruction(Instruction), .IF_valid(IF_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  task automatic do_reset(input logic pulse_ready);
    rst = 1'b1;
    freeze = 1'b0;
    Branch_taken = 1'b0;
    imem_ready = pulse_ready;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b0;
    m_pc = 32'd0;
    mo_pc = 32'd0;
    mo_ins = NOP;
    mo_v = 1'b0;
    drop = 1'b0;
    hbuf.delete();
    wait_cnt = 0;
    cur_lat = $urandom_range(lat_hi, lat_lo);
    #1;
  endtask

  task automatic tick(input logic fr, input logic br, input logic [31:0] ba);
    logic ereq, rdy;
    logic [31:0] rd;
    freeze = fr;
    Branch_taken = br;
    Branch_Address = ba;
    ereq = hbuf.size() == 0;
    rdy = ereq ? (wait_cnt >= cur_lat) : ($urandom_range(0, 3) == 0);
    rd = ereq ? word(m_pc) : $urandom;
    imem_ready = rdy;
    imem_rdata = rd;
    #1;
    compared++;
    if (imem_req !== ereq) begin
      mismatched++;
      $display("FAIL imem_req: got %b want %b at %0t", imem_req, ereq, $time);
    end
    if (ereq) begin
      compared++;
      if (imem_addr !== m_pc) begin
        mismatched++;
        $display("FAIL imem_addr: got %h want %h at %0t", imem_addr, m_pc, $time);
      end
    end
    @(posedge clk);
    rdy = rdy & ereq;
    if (br) begin
      mo_pc = 32'd0;
      mo_ins = NOP;
      mo_v = 1'b0;
      hbuf.delete();
      if (!ereq || rdy) begin
        m_pc = ba & ~32'd3;
        drop = 1'b0;
      end else begin
        tgt = ba & ~32'd3;
        drop = 1'b1;
      end
    end else if (!ereq) begin
      if (!fr) begin
        {mo_pc, mo_ins} = hbuf.pop_front();
        mo_v = 1'b1;
      end
    end else if (drop) begin
      if (rdy) begin
        m_pc = tgt;
        drop = 1'b0;
      end
      if (!fr) begin
        mo_ins = NOP;
        mo_v = 1'b0;
      end
    end else if (rdy) begin
      if (fr) hbuf.push_back({m_pc + 32'd4, rd});
      else begin
        mo_pc = m_pc + 32'd4;
        mo_ins = rd;
        mo_v = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!fr) begin
      mo_ins = NOP;
      mo_v = 1'b0;
    end
    if (ereq) begin
      if (rdy) begin
        wait_cnt = 0;
        cur_lat = $urandom_range(lat_hi, lat_lo);
      end else wait_cnt++;
    end
    #1;
    compared += 3;
    if (PC !== mo_pc) begin
      mismatched++;
      $display("FAIL PC: got %h want %h at %0t", PC, mo_pc, $time);
    end
    if (Instruction !== mo_ins) begin
      mismatched++;
      $display("FAIL Instruction: got %h want %h at %0t", Instruction, mo_ins, $time);
    end
    if (IF_valid !== mo_v) begin
      mismatched++;
      $display("FAIL IF_valid: got %b want %b at %0t", IF_valid, mo_v, $time);
    end
    @(negedge clk);
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_lo = lo;
    lat_hi = hi;
    cur_lat = lo;
  endtask

  task automatic test_reset;
    set_lat(0, 0);
    do_reset(1'b0);
    compared++;
    if (PC !== 32'd0 || Instruction !== NOP || IF_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      mismatched++;
      $display("FAIL reset: got pc=%h ins=%h v=%b req=%b addr=%h want 0/%h/0/1/0", PC, Instruction, IF_valid, imem_req, imem_addr, NOP);
    end
  endtask

  task automatic test_straight;
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, 1'b0, 32'd0);
      compared++;
      if (PC !== 32'(4 * i) || Instruction !== word(32'(4 * (i - 1))) || IF_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL straight%0d: got pc=%h ins=%h v=%b want pc=%h ins=%h v=1", i, PC, Instruction, IF_valid, 4 * i, word(32'(4 * (i - 1))));
      end
    end
  endtask

  task automatic test_multicycle;
    int valids = 0;
    set_lat(2, 2);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 32'd0);
      valids += int'(IF_valid);
    end
    compared++;
    if (PC !== 32'd20 || valids != 2) begin
      mismatched++;
      $display("FAIL multicycle: got pc=%h valids=%0d want pc=00000014 valids=2", PC, valids);
    end
  endtask

  task automatic test_freeze;
    set_lat(0, 0);
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'd0);
    compared++;
    if (PC !== 32'h10 || Instruction !== word(32'hC) || imem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL freeze_hold: got pc=%h ins=%h req=%b want pc=00000010 ins=%h req=0", PC, Instruction, imem_req, word(32'hC));
    end
    tick(1'b0, 1'b0, 32'd0);
    compared++;
    if (PC !== 32'h14 || Instruction !== word(32'h10) || IF_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL freeze_release: got pc=%h ins=%h v=%b want pc=00000014 ins=%h v=1", PC, Instruction, IF_valid, word(32'h10));
    end
    tick(1'b0, 1'b0, 32'd0);
    compared++;
    if (PC !== 32'h18) begin
      mismatched++;
      $display("FAIL freeze_next: got pc=%h want 00000018", PC);
    end
  endtask

  task automatic test_branch_same;
    tick(1'b0, 1'b1, 32'h100);
    compared++;
    if (IF_valid !== 1'b0 || imem_addr !== 32'h100) begin
      mismatched++;
      $display("FAIL branch_same: got v=%b addr=%h want v=0 addr=00000100", IF_valid, imem_addr);
    end
    tick(1'b0, 1'b0, 32'd0);
    compared++;
    if (PC !== 32'h104 || Instruction !== word(32'h100)) begin
      mismatched++;
      $display("FAIL branch_same_load: got pc=%h ins=%h want pc=00000104 ins=%h", PC, Instruction, word(32'h100));
    end
  endtask

  task automatic test_branch_outstanding;
    lat_lo = 3;
    lat_hi = 3;
    tick(1'b0, 1'b1, 32'h20);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 32'h200);
    compared++;
    if (IF_valid !== 1'b0 || PC !== 32'd0 || imem_addr !== 32'h20) begin
      mismatched++;
      $display("FAIL branch_out_flush: got v=%b pc=%h addr=%h want v=0 pc=0 addr=00000020", IF_valid, PC, imem_addr);
    end
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    compared++;
    if (IF_valid !== 1'b0 || imem_addr !== 32'h200) begin
      mismatched++;
      $display("FAIL branch_out_drain: got v=%b addr=%h want v=0 addr=00000200", IF_valid, imem_addr);
    end
  endtask

  task automatic test_random;
    set_lat(0, 3);
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
  endtask

  task automatic test_wrap_reset;
    set_lat(0, 0);
    tick(1'b0, 1'b1, 32'hFFFF_FFFE);
    tick(1'b0, 1'b0, 32'd0);
    compared++;
    if (PC !== 32'd0 || Instruction !== word(32'hFFFF_FFFC) || IF_valid !== 1'b1 || imem_addr !== 32'd0) begin
      mismatched++;
      $display("FAIL wrap: got pc=%h ins=%h v=%b addr=%h want pc=0 ins=%h v=1 addr=0", PC, Instruction, IF_valid, imem_addr, word(32'hFFFF_FFFC));
    end
    tick(1'b0, 1'b0, 32'd0);
    set_lat(3, 3);
    tick(1'b0, 1'b0, 32'd0);
    do_reset(1'b1);
    compared++;
    if (PC !== 32'd0 || Instruction !== NOP || IF_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_mid: got pc=%h ins=%h v=%b req=%b addr=%h want 0/%h/0/1/0", PC, Instruction, IF_valid, imem_req, imem_addr, NOP);
    end
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_straight;
    test_multicycle;
    test_freeze;
    test_branch_same;
    test_branch_outstanding;
    test_random;
    test_wrap_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
